// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM state codes,
// and the lane-mask / load-extend helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  // Byte lanes touched by an access; lane is assumed already aligned for half/word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << lane;
      SZ_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{~is_unsigned & b[7]}}, b};
      SZ_HALF: res = {{16{~is_unsigned & h[15]}}, h};
      SZ_WORD: res = word;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core's memory stage (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous byte-enabled write, combinational read, no reset.
module dmem_array #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES extra cycles, byte/half/word access.
// Optional DMEM_MISALIGN_TRAP_EN faults misaligned half/word accesses instead of force-aligning.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  CntInit = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        accept;
  logic        out_of_range;
  logic        misaligned;
  logic        fault;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic [31:0] word;
  logic [31:0] rdata_d;

  assign accept = (state_q == StIdle) && bus.req_valid && req_ready_q;

  assign out_of_range = {2'b00, addr_q[31:2]} >= DEPTH;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = ((size_q == SZ_HALF) && addr_q[0]) ||
                      ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign fault = out_of_range || misaligned || (size_q == 2'b11);

  // Low address bits are dropped for half/word; only matters when misalignment is not trapped.
  always_comb begin
    lane = addr_q[1:0];
    if (size_q == SZ_HALF) lane = {addr_q[1], 1'b0};
    else if (size_q == SZ_WORD) lane = 2'b00;
  end

  always_comb begin
    case (size_q)
      SZ_BYTE: wdata_lanes = {4{wdata_q[7:0]}};
      SZ_HALF: wdata_lanes = {2{wdata_q[15:0]}};
      default: wdata_lanes = wdata_q;
    endcase
  end

  // Reset gates the write so an abandoned store never lands.
  assign be = (reset && (state_q == StAccess) && we_q && !fault) ? lane_mask(size_q, lane)
                                                                 : 4'b0000;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (clk),
    .be_i   (be),
    .addr_i (addr_q[AW+1:2]),
    .wdata_i(wdata_lanes),
    .rdata_o(word)
  );

  assign rdata_d = (we_q || fault) ? 32'h0 : extend_load(word, size_q, lane, uns_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StAccess;
      end
      StAccess: state_d = StResp;
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == StIdle);
      if (state_q == StAccess) begin
        rdata_q <= rdata_d;
        err_q   <= fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) checked against a byte-level
// memory model built from the access rules.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS0   = 0;
  localparam int unsigned WS1   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic        drv_valid [2];
  logic        drv_we    [2];
  logic [31:0] drv_addr  [2];
  logic [31:0] drv_wdata [2];
  logic [1:0]  drv_size  [2];
  logic        drv_uns   [2];
  logic        drv_rready[2];
  logic        mon_ready [2];
  logic        mon_valid [2];
  logic [31:0] mon_rdata [2];
  logic        mon_err   [2];

  assign bus0.req_valid    = drv_valid[0];
  assign bus0.req_we       = drv_we[0];
  assign bus0.req_addr     = drv_addr[0];
  assign bus0.req_wdata    = drv_wdata[0];
  assign bus0.req_size     = drv_size[0];
  assign bus0.req_unsigned = drv_uns[0];
  assign bus0.rsp_ready    = drv_rready[0];
  assign bus1.req_valid    = drv_valid[1];
  assign bus1.req_we       = drv_we[1];
  assign bus1.req_addr     = drv_addr[1];
  assign bus1.req_wdata    = drv_wdata[1];
  assign bus1.req_size     = drv_size[1];
  assign bus1.req_unsigned = drv_uns[1];
  assign bus1.rsp_ready    = drv_rready[1];
  assign mon_ready[0] = bus0.req_ready;
  assign mon_valid[0] = bus0.rsp_valid;
  assign mon_rdata[0] = bus0.rsp_rdata;
  assign mon_err[0]   = bus0.rsp_err;
  assign mon_ready[1] = bus1.req_ready;
  assign mon_valid[1] = bus1.rsp_valid;
  assign mon_rdata[1] = bus1.rsp_rdata;
  assign mon_err[1]   = bus1.rsp_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [2][DEPTH];
  logic [31:0] exp_rdata, got_rdata;
  logic        exp_err, got_err;
  int          got_lat;
  bit          got_ok, got_stable, got_post;

  // Byte-level reference: fault rules first, then per-byte copy and arithmetic extension.
  function automatic void model_access(input int sel, input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [1:0] size,
                                       input logic uns, output logic [31:0] rdata,
                                       output logic err);
    int nb, off, w;
    logic [31:0] aa, v;
    rdata = 32'h0;
    err   = 1'b0;
    if (size == 2'b11 || (addr >> 2) >= DEPTH) begin
      err = 1'b1;
      return;
    end
    nb = 1 << size;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((addr % nb) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    aa  = addr & ~32'(nb - 1);
    off = int'(aa[1:0]);
    w   = int'(aa >> 2);
    if (we) begin
      for (int i = 0; i < nb; i++) mdl[sel][w][8*(off+i) +: 8] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[sel][w][8*(off+i) +: 8];
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rdata = v;
    end
  endfunction

  function automatic int exp_lat(input int sel);
    return 1 + int'(sel == 0 ? WS0 : WS1);
  endfunction

  // One full transaction; called and returns #1 after a rising edge.
  task automatic run(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input int stall);
    int n;
    model_access(sel, we, addr, wdata, size, uns, exp_rdata, exp_err);
    got_ok = 1; got_stable = 1; got_post = 0; got_lat = 0;
    got_rdata = 'x; got_err = 1'bx;
    n = 0;
    while (mon_ready[sel] !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin got_ok = 0; return; end
    drv_we[sel] = we; drv_addr[sel] = addr; drv_wdata[sel] = wdata;
    drv_size[sel] = size; drv_uns[sel] = uns; drv_valid[sel] = 1'b1;
    @(posedge clk); #1;
    // Scramble request fields: the responder must have latched them.
    drv_valid[sel] = 1'b0; drv_we[sel] = 1'($urandom); drv_addr[sel] = $urandom;
    drv_wdata[sel] = $urandom; drv_size[sel] = 2'($urandom); drv_uns[sel] = 1'($urandom);
    while (mon_valid[sel] !== 1'b1 && got_lat < 100) begin @(posedge clk); #1; got_lat++; end
    if (got_lat >= 100) begin got_ok = 0; return; end
    got_rdata = mon_rdata[sel];
    got_err   = mon_err[sel];
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (mon_valid[sel] !== 1'b1 || mon_rdata[sel] !== got_rdata || mon_err[sel] !== got_err ||
          mon_ready[sel] !== 1'b0) got_stable = 0;
    end
    drv_rready[sel] = 1'b1;
    @(posedge clk); #1;
    drv_rready[sel] = 1'b0;
    got_post = (mon_ready[sel] === 1'b1) && (mon_valid[sel] === 1'b0);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      drv_valid[s] = 0; drv_we[s] = 0; drv_addr[s] = 0; drv_wdata[s] = 0;
      drv_size[s] = 0; drv_uns[s] = 0; drv_rready[s] = 0;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      total++;
      if (mon_ready[s] !== 0 || mon_valid[s] !== 0 || mon_rdata[s] !== 0 || mon_err[s] !== 0) begin
        bad++;
        $display("FAIL reset_state[%0d]: ready=%b valid=%b rdata=%h err=%b, need all 0", s,
                 mon_ready[s], mon_valid[s], mon_rdata[s], mon_err[s]);
      end
    end
    reset = 1'b1;
    #1;
    total++;
    if (mon_ready[0] !== 0 || mon_ready[1] !== 0) begin
      bad++;
      $display("FAIL reset_first_cycle: ready=%b/%b, need 0/0", mon_ready[0], mon_ready[1]);
    end
    @(posedge clk); #1;
    total++;
    if (mon_ready[0] !== 1 || mon_ready[1] !== 1 || mon_valid[0] !== 0 || mon_valid[1] !== 0) begin
      bad++;
      $display("FAIL reset_ready_rise: ready=%b/%b valid=%b/%b, need 1/1 0/0", mon_ready[0],
               mon_ready[1], mon_valid[0], mon_valid[1]);
    end
  endtask

  task automatic test_word();
    run(0, 1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, 0);
    total++;
    if (!got_ok || got_lat != 1 || got_err !== 0 || got_rdata !== 0 || !got_post) begin
      bad++;
      $display("FAIL sw_word: ok=%0b lat=%0d err=%b rdata=%h post=%0b, need 1 1 0 0 1", got_ok,
               got_lat, got_err, got_rdata, got_post);
    end
    run(0, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b1, 0);
    total++;
    if (!got_ok || got_lat != 1 || got_err !== 0 || got_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lw_word: ok=%0b lat=%0d err=%b rdata=%h, need 1 1 0 deadbeef", got_ok,
               got_lat, got_err, got_rdata);
    end
  endtask

  task automatic test_byte_lanes();
    run(0, 1'b1, 32'h20, 32'h11223344, SZ_WORD, 1'b0, 0);
    run(0, 1'b1, 32'h21, 32'h5A5A5A80, SZ_BYTE, 1'b0, 0);
    total++;
    if (!got_ok || got_err !== 0) begin
      bad++;
      $display("FAIL sb_lane1: ok=%0b err=%b, need 1 0", got_ok, got_err);
    end
    run(0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 0);
    total++;
    if (got_rdata !== 32'h11228044 || got_err !== 0) begin
      bad++;
      $display("FAIL sb_merge: rdata=%h err=%b, need 11228044 0", got_rdata, got_err);
    end
    run(0, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b0, 0);
    total++;
    if (got_rdata !== 32'hFFFFFF80 || got_err !== 0) begin
      bad++;
      $display("FAIL lb_sign: rdata=%h err=%b, need ffffff80 0", got_rdata, got_err);
    end
    run(0, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b1, 0);
    total++;
    if (got_rdata !== 32'h00000080 || got_err !== 0) begin
      bad++;
      $display("FAIL lbu_zero: rdata=%h err=%b, need 00000080 0", got_rdata, got_err);
    end
  endtask

  task automatic test_errors();
    run(0, 1'b0, DEPTH * 4, 32'h0, SZ_WORD, 1'b0, 0);
    total++;
    if (got_err !== 1 || got_rdata !== 0 || got_lat != 1) begin
      bad++;
      $display("FAIL oor_load: err=%b rdata=%h lat=%0d, need 1 0 1", got_err, got_rdata, got_lat);
    end
    run(0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0);
    total++;
    if (got_err !== 1 || got_rdata !== 0) begin
      bad++;
      $display("FAIL size11_load: err=%b rdata=%h, need 1 0", got_err, got_rdata);
    end
    run(0, 1'b1, 32'h10, 32'h0, 2'b11, 1'b0, 0);
    run(0, 1'b1, DEPTH * 4 + 32'h10, 32'h0, SZ_WORD, 1'b0, 0);
    total++;
    if (got_err !== 1 || got_rdata !== 0) begin
      bad++;
      $display("FAIL oor_store: err=%b rdata=%h, need 1 0", got_err, got_rdata);
    end
    run(0, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 0);
    total++;
    if (got_err !== 0 || got_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL err_no_write: err=%b rdata=%h, need 0 deadbeef", got_err, got_rdata);
    end
  endtask

  task automatic test_misalign();
    logic        want_err;
    logic [31:0] want_word;
`ifdef DMEM_MISALIGN_TRAP_EN
    want_err  = 1'b1;
    want_word = 32'h55667788;
`else
    want_err  = 1'b0;
    want_word = 32'hABCD7788;
`endif
    run(0, 1'b1, 32'h0, 32'h55667788, SZ_WORD, 1'b0, 0);
    run(0, 1'b1, 32'h3, 32'h1234ABCD, SZ_HALF, 1'b0, 0);
    total++;
    if (got_err !== want_err || got_rdata !== 0) begin
      bad++;
      $display("FAIL sh_misalign: err=%b rdata=%h, need %b 0", got_err, got_rdata, want_err);
    end
    run(0, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0, 0);
    total++;
    if (got_rdata !== want_word) begin
      bad++;
      $display("FAIL sh_misalign_word: rdata=%h, need %h", got_rdata, want_word);
    end
  endtask

  task automatic test_stall();
    run(1, 1'b1, 32'h80, 32'hCAFEF00D, SZ_WORD, 1'b0, 5);
    total++;
    if (!got_ok || got_lat != 4 || !got_stable || !got_post || got_err !== 0) begin
      bad++;
      $display("FAIL stall_store: ok=%0b lat=%0d stable=%0b post=%0b err=%b, need 1 4 1 1 0",
               got_ok, got_lat, got_stable, got_post, got_err);
    end
    run(1, 1'b0, 32'h80, 32'h0, SZ_WORD, 1'b0, 5);
    total++;
    if (!got_ok || got_lat != 4 || !got_stable || !got_post || got_rdata !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL stall_load: ok=%0b lat=%0d stable=%0b post=%0b rdata=%h, need 1 4 1 1 cafef00d",
               got_ok, got_lat, got_stable, got_post, got_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    run(1, 1'b1, 32'h40, 32'h0BADF00D, SZ_WORD, 1'b0, 0);
    drv_we[1] = 1'b1; drv_addr[1] = 32'h40; drv_wdata[1] = 32'h12345678;
    drv_size[1] = SZ_WORD; drv_uns[1] = 1'b0; drv_valid[1] = 1'b1;
    @(posedge clk); #1;
    drv_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (mon_valid[1] !== 1'b0) seen = 1; end
    reset = 1'b1;
    #1;
    total++;
    if (mon_ready[1] !== 1'b0) begin
      bad++;
      $display("FAIL midrst_first: ready=%b, need 0", mon_ready[1]);
    end
    @(posedge clk); #1;
    total++;
    if (mon_ready[1] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_ready: ready=%b, need 1", mon_ready[1]);
    end
    repeat (6) begin @(posedge clk); #1; if (mon_valid[1] !== 1'b0) seen = 1; end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL midrst_no_rsp: rsp_valid seen=1, need 0");
    end
    run(1, 1'b0, 32'h40, 32'h0, SZ_WORD, 1'b0, 0);
    total++;
    if (got_rdata !== 32'h0BADF00D || got_err !== 0) begin
      bad++;
      $display("FAIL midrst_keep: rdata=%h err=%b, need 0badf00d 0", got_rdata, got_err);
    end
  endtask

  task automatic test_random();
    int          sel, stall;
    logic        we, uns;
    logic [31:0] addr;
    logic [1:0]  size;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 32; w++) begin
        run(s, 1'b1, 32'(w * 4), $urandom, SZ_WORD, 1'b0, 0);
        total++;
        if (!got_ok || got_err !== 0) begin
          bad++;
          $display("FAIL rnd_init[%0d][%0d]: ok=%0b err=%b, need 1 0", s, w, got_ok, got_err);
        end
      end
    end
    for (int k = 0; k < 150; k++) begin
      sel   = int'($urandom_range(0, 1));
      we    = 1'($urandom);
      uns   = 1'($urandom);
      size  = 2'($urandom);
      stall = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) addr = DEPTH * 4 + $urandom_range(0, 4095);
      else addr = $urandom_range(0, 127);
      run(sel, we, addr, $urandom, size, uns, stall);
      total++;
      if (!got_ok || got_lat != exp_lat(sel) || got_err !== exp_err || got_rdata !== exp_rdata ||
          !got_stable || !got_post) begin
        bad++;
        $display("FAIL rnd[%0d] sel=%0d we=%b addr=%h size=%0d uns=%b: ok=%0b lat=%0d err=%b rdata=%h stable=%0b post=%0b, need lat=%0d err=%b rdata=%h",
                 k, sel, we, addr, size, uns, got_ok, got_lat, got_err, got_rdata, got_stable,
                 got_post, exp_lat(sel), exp_err, exp_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_errors();
    test_misalign();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core: the slave end of the load/store port the datapath drives with ALUResult as address and RD2 as write data. It accepts one request at a time over a valid/ready handshake, applies a configurable number of wait states, performs a byte/half/word access on an internal word array, and returns sign- or zero-extended load data plus an error flag. It sits between the core's memory-stage initiator and on-chip RAM, so the core can run against non-zero memory latency.

## Interface
- `DEPTH`, 1024 — number of 32-bit words; power of two.
- `WAIT_STATES`, 0 — extra cycles between accept and response; legal range 0..15.
- `clk` in 1 — rising-edge clock.
- `reset` in 1 — synchronous reset, **active-low**.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — responder can accept.
- `req_we` in 1 — 1 = store, 0 = load.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data, right-aligned.
- `req_size` in 2 — 00 byte, 01 half, 10 word; 11 is an error.
- `req_unsigned` in 1 — zero-extend load data (LBU/LHU).
- `rsp_valid` out 1 — response present.
- `rsp_ready` in 1 — initiator takes response.
- `rsp_rdata` out 32 — extended load data; 0 for stores and errors.
- `rsp_err` out 1 — access faulted.

## Operation
- FSM states:
  - **IDLE**: `req_ready`=1. On `req_valid`&&`req_ready`, latch we/addr/wdata/size/unsigned and go to WAIT. If `WAIT_STATES`=0, go directly to ACCESS.
  - **WAIT**: a down-counter loaded with `WAIT_STATES` decrements each cycle. At 1, go to ACCESS.
  - **ACCESS**: one cycle. Read the word, compute the response, commit any store, then go to RESP.
  - **RESP**: `rsp_valid`=1, with data and err held stable. On `rsp_ready`, go to IDLE.
- Word index is `addr[log2(DEPTH)+1:2]`. Lane is `addr[1:0]`.
- Out of range: `addr[31:2]` ≥ DEPTH. Result: `rsp_err`=1, no write, rdata=0.
- `req_size`=11: `rsp_err`=1, no write.
- Store: read-modify-write of the selected lanes only. Byte uses `wdata[7:0]`; half uses `wdata[15:0]`.
- Load: extract the lane(s), then sign- or zero-extend to 32 bits. A word load ignores `req_unsigned`.
- Inputs are ignored outside IDLE. `req_ready`=0 in WAIT, ACCESS and RESP; there is no pipelining.
- The memory array is not cleared by reset.

## Timing
- During reset and on the first cycle after it: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE, counter 0.
- `req_ready` is registered. It is 1 in IDLE, from the second cycle after reset deasserts.
- Latency: request accepted at edge N → `rsp_valid` high after edge N+1+`WAIT_STATES`.
- The store commits at the ACCESS→RESP edge. A load issued immediately afterwards sees the new data.
- `rsp_valid` stays high until `rsp_ready`. The handshake edge returns the FSM to IDLE, and `req_ready`=1 on the following cycle. Minimum throughput is one request per 3+`WAIT_STATES` cycles.
- Reset asserted mid-operation (WAIT/ACCESS/RESP) abandons the request. A store not yet past the ACCESS edge is not written, and no response is produced.
- `rsp_rdata` and `rsp_err` are registered and change only at entry to RESP or on reset.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]`=1 gives `rsp_err`=1, no write, rdata=0.
  - A word access with `addr[1:0]`≠0 gives the same result.
- Not defined:
  - Misaligned addresses are force-aligned by clearing the low bits: `addr[0]` for half, `addr[1:0]` for word.
  - The access proceeds normally with `rsp_err`=0.

## Structure
- Package `dmem_pkg` holds:
  - the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD);
  - the state enum (IDLE/WAIT/ACCESS/RESP);
  - the lane-mask and extend helper functions.
- Sub-module `dmem_array`: DEPTH×32 synchronous-write, combinational-read storage with a 4-bit byte-write enable. The FSM, counter, lane logic and error checks live in `dmem_responder`.

## Test plan
- `WAIT_STATES`=0: store word 0xDEADBEEF @0x10, then load word @0x10 → rdata 0xDEADBEEF, err 0. Each `rsp_valid` rises 1 cycle after accept.
- Store byte 0x80 @0x21 over 0x11223344 @0x20:
  - word becomes 0x11228044;
  - LB @0x21 → 0xFFFFFF80;
  - LBU @0x21 → 0x00000080.
- `WAIT_STATES`=3 with `rsp_ready` held low 5 cycles:
  - `rsp_valid` rises 4 cycles after accept;
  - data stays stable while stalled;
  - `req_ready` returns 1 cycle after the handshake.
- Load @(DEPTH×4), or `req_size`=11 → err 1, rdata 0, and a following load shows memory unchanged.
- Half store 0xABCD @0x03:
  - with `DMEM_MISALIGN_TRAP_EN`: err 1, no write;
  - without it: writes lanes 2–3 of word 0 and err 0.
- Reset pulled low during WAIT of a store to @0x40 → no response, @0x40 keeps its old value, `req_ready`=1 two cycles after release.
